timer_mc: RTL and testbench
===========================

Name: timer_mc

Overview:
- Multi-channel, parametrised general-purpose timer for the SoC timer peripheral.
- Each channel has an up-counter with a per-channel clock prescaler, latched compare and prescale values, and single-shot or continuous mode.
- Each channel raises a one-cycle match pulse and a sticky match flag that software clears.
- The register-interface wrapper drives the control inputs and reads the status outputs; channel outputs feed the interrupt controller.

Parameters:
- WIDTH, 32, counter and compare width in bits (>=2).
- CHANNELS, 4, number of independent timer channels (>=1).
- PSC_WIDTH, 8, prescaler width in bits (>=1).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- trigger  input  CHANNELS  per-channel start request, level-sampled.
- halt  input  CHANNELS  per-channel stop request.
- single_shot  input  CHANNELS  mode select, sampled at start: 1 = single-shot, 0 = continuous.
- compare_value  input  CHANNELS*WIDTH  per-channel compare; channel i uses bits [i*WIDTH +: WIDTH].
- prescale  input  CHANNELS*PSC_WIDTH  per-channel divider; tick every prescale+1 cycles.
- match_clear  input  CHANNELS  clears the sticky match flag.
- active  output  CHANNELS  channel in COUNT state.
- match_occurred  output  CHANNELS  one-cycle match pulse.
- match_flag  output  CHANNELS  sticky match flag.
- counter  output  CHANNELS*WIDTH  per-channel current count.

Behaviour:
- Reset: synchronous to clk, active-low (rst_n==0 sampled on a rising edge). All channels go to IDLE; counter=0, prescaler count=0, latched compare=0, latched prescale=0, mode=SINGLE_SHOT, match_flag=0. Combinational outputs active=0 and match_occurred=0 follow from that state. Reset mid-count aborts immediately with no match pulse.
- Channels are fully independent; describe one channel i.
- States: IDLE, COUNT.
- IDLE:
  - trigger=1 and halt=0 -> COUNT next cycle.
  - On that edge latch compare_value, prescale and mode (single_shot ? SINGLE_SHOT : CONTINUOUS). Clear counter and prescaler count to 0.
  - halt=1 in IDLE: stay IDLE; halt beats a simultaneous trigger.
- COUNT:
  - Prescaler count psc increments every cycle.
  - tick = (psc == latched prescale); on tick psc <- 0. With prescale=0, tick=1 every cycle.
  - halt=1 -> IDLE next cycle; counter and psc <- 0; no match pulse that cycle even if a match would occur.
  - tick and counter==latched compare -> match:
    - counter <- 0, psc <- 0.
    - SINGLE_SHOT -> IDLE; CONTINUOUS -> stay in COUNT.
  - tick and no match -> counter <- counter+1, modulo 2^WIDTH (unreachable when compare < 2^WIDTH-1; compare = all-ones wraps naturally to match).
  - No tick -> counter holds.
  - trigger while in COUNT is ignored: no restart, no re-latch.
  - Changes to compare_value, prescale or single_shot while in COUNT have no effect until the next start.
- Period: (compare+1)*(prescale+1) clk cycles from COUNT entry to first match; continuous mode repeats the same period.
- Outputs:
  - active = (state==COUNT), combinational from state.
  - match_occurred = active & ~halt & tick & (counter==latched compare), combinational. It is asserted in the cycle before counter returns to 0.
  - counter reflects the registered count. It reads 0 in IDLE after any stop; reset, halt and single-shot completion all clear it.
- match_flag, registered:
  - Set on the edge after match_occurred=1.
  - Cleared by match_clear=1.
  - Simultaneous set and clear: set wins, flag stays 1.
- compare=0, prescale=0: match every cycle in continuous mode (match_occurred held high). Single-shot: one cycle in COUNT, one pulse, then IDLE.
- No combinational path from trigger to any output. Combinational path from halt to match_occurred only.

Test Plan:
- Reset: assert rst_n=0 for 2 cycles mid-count on all channels -> next edge active=0, counter=0, match_flag=0; no match pulse.
- Single-shot, no prescale: ch0 compare=5, prescale=0, single_shot=1, trigger 1 cycle -> active for 6 cycles, counter 0..5; match_occurred exactly once at counter=5; then IDLE, counter=0, match_flag=1.
- Continuous with prescale: ch1 compare=3, prescale=2, single_shot=0 -> match_occurred every 12 cycles, 3 pulses in 36 cycles; counter holds 3 cycles per value; active stays 1.
- Halt and trigger conflicts: halt at counter=2 in continuous mode -> IDLE next cycle, counter=0, no pulse. Trigger+halt together in IDLE -> remains IDLE. Trigger in COUNT -> no restart.
- Latching and independence: change compare_value from 5 to 1 mid-count on ch2 -> match still at 5. ch3 run simultaneously with compare=0, prescale=0, continuous -> pulse every cycle, ch2 unaffected.
- Flag priority and wrap: match_clear coincident with a match edge -> match_flag stays 1; match_clear alone -> 0. WIDTH=4 instance, compare=15 -> match at counter=15, then counter=0.

Source files
------------

// File: rtl/timer_mc.sv
// timer_mc: multi-channel general-purpose timer.
// Each channel runs an up-counter behind its own prescaler. The compare value,
// prescale value and mode are captured when the channel starts. A channel
// raises a one-cycle match pulse and a sticky flag that software clears.
module timer_mc #(
    parameter int WIDTH     = 32,
    parameter int CHANNELS  = 4,
    parameter int PSC_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CHANNELS-1:0]           trigger,
    input  logic [CHANNELS-1:0]           halt,
    input  logic [CHANNELS-1:0]           single_shot,
    input  logic [CHANNELS*WIDTH-1:0]     compare_value,
    input  logic [CHANNELS*PSC_WIDTH-1:0] prescale,
    input  logic [CHANNELS-1:0]           match_clear,
    output logic [CHANNELS-1:0]           active,
    output logic [CHANNELS-1:0]           match_occurred,
    output logic [CHANNELS-1:0]           match_flag,
    output logic [CHANNELS*WIDTH-1:0]     counter
);

    localparam logic ST_IDLE     = 1'b0;
    localparam logic ST_COUNT    = 1'b1;
    localparam logic MODE_SINGLE = 1'b1;
    localparam logic MODE_CONT   = 1'b0;

    genvar g;
    generate
        for (g = 0; g < CHANNELS; g = g + 1) begin : g_ch
            logic                 r_state;
            logic                 r_mode;
            logic                 r_flag;
            logic [WIDTH-1:0]     r_cnt;
            logic [WIDTH-1:0]     r_cmp;
            logic [PSC_WIDTH-1:0] r_psc;
            logic [PSC_WIDTH-1:0] r_psc_lat;
            logic                 w_tick;
            logic                 w_hit;
            logic                 w_match;

            // Prescaler tick, compare hit and the externally visible match pulse.
            // Halt suppresses the pulse in the cycle it stops the channel.
            always_comb begin
                w_tick  = (r_psc == r_psc_lat);
                w_hit   = w_tick && (r_cnt == r_cmp);
                w_match = (r_state == ST_COUNT) && !halt[g] && w_hit;
            end

            // Channel state machine: start/latch from IDLE, count, stop on halt or single-shot match.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_state   <= ST_IDLE;
                    r_mode    <= MODE_SINGLE;
                    r_cnt     <= {WIDTH{1'b0}};
                    r_cmp     <= {WIDTH{1'b0}};
                    r_psc     <= {PSC_WIDTH{1'b0}};
                    r_psc_lat <= {PSC_WIDTH{1'b0}};
                end else begin
                    case (r_state)
                        ST_IDLE: begin
                            if (trigger[g] && !halt[g]) begin
                                r_state   <= ST_COUNT;
                                r_cmp     <= compare_value[g*WIDTH +: WIDTH];
                                r_psc_lat <= prescale[g*PSC_WIDTH +: PSC_WIDTH];
                                r_mode    <= single_shot[g] ? MODE_SINGLE : MODE_CONT;
                                r_cnt     <= {WIDTH{1'b0}};
                                r_psc     <= {PSC_WIDTH{1'b0}};
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end
                        ST_COUNT: begin
                            if (halt[g]) begin
                                r_state <= ST_IDLE;
                                r_cnt   <= {WIDTH{1'b0}};
                                r_psc   <= {PSC_WIDTH{1'b0}};
                            end else if (w_hit) begin
                                r_cnt   <= {WIDTH{1'b0}};
                                r_psc   <= {PSC_WIDTH{1'b0}};
                                r_state <= (r_mode == MODE_SINGLE) ? ST_IDLE : ST_COUNT;
                            end else if (w_tick) begin
                                r_cnt <= r_cnt + WIDTH'(1'b1);
                                r_psc <= {PSC_WIDTH{1'b0}};
                            end else begin
                                r_psc <= r_psc + PSC_WIDTH'(1'b1);
                            end
                        end
                        default: begin
                            r_state <= ST_IDLE;
                            r_cnt   <= {WIDTH{1'b0}};
                            r_psc   <= {PSC_WIDTH{1'b0}};
                        end
                    endcase
                end
            end

            // Sticky match flag: a new match takes priority over a clear in the same cycle.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_flag <= 1'b0;
                end else if (w_match) begin
                    r_flag <= 1'b1;
                end else if (match_clear[g]) begin
                    r_flag <= 1'b0;
                end else begin
                    r_flag <= r_flag;
                end
            end

            assign active[g]                     = (r_state == ST_COUNT);
            assign match_occurred[g]             = w_match;
            assign match_flag[g]                 = r_flag;
            assign counter[g*WIDTH +: WIDTH]     = r_cnt;
        end
    endgenerate

endmodule

// File: tb/tb_timer_mc.sv
// Scoreboard bench for timer_mc. A stimulus process drives inputs and pushes
// the expected outputs of each cycle (from an elapsed-time model) into a queue;
// a monitor pops and compares on the falling edge.
module tb_timer_mc;
    localparam int W  = 4;
    localparam int C  = 4;
    localparam int PW = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [C-1:0]    trigger, halt, single_shot, match_clear;
    logic [C*W-1:0]  compare_value;
    logic [C*PW-1:0] prescale;
    logic [C-1:0]    active, match_occurred, match_flag;
    logic [C*W-1:0]  counter;

    timer_mc #(.WIDTH(W), .CHANNELS(C), .PSC_WIDTH(PW)) dut (
        .clk(clk), .rst_n(rst_n), .trigger(trigger), .halt(halt),
        .single_shot(single_shot), .compare_value(compare_value),
        .prescale(prescale), .match_clear(match_clear), .active(active),
        .match_occurred(match_occurred), .match_flag(match_flag),
        .counter(counter)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [C-1:0]   act;
        logic [C-1:0]   mat;
        logic [C-1:0]   flg;
        logic [C*W-1:0] cnt;
        int             cyc;
    } exp_t;

    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;

    // Reference model: a running channel is described only by cycles elapsed since start.
    bit     m_run[C];
    bit     m_flag[C];
    bit     m_ss[C];
    longint m_e[C];
    int     m_cmp[C];
    int     m_psc[C];

    function automatic exp_t model_outputs();
        exp_t e;
        e.act = '0; e.mat = '0; e.flg = '0; e.cnt = '0; e.cyc = cycle;
        for (int i = 0; i < C; i++) begin
            longint p, ph;
            p  = longint'(m_cmp[i] + 1) * longint'(m_psc[i] + 1);
            ph = m_e[i] % p;
            e.act[i] = m_run[i];
            e.flg[i] = m_flag[i];
            e.mat[i] = m_run[i] && !halt[i] && (ph == p - 1);
            e.cnt[i*W +: W] = m_run[i] ? W'(ph / longint'(m_psc[i] + 1)) : W'(0);
        end
        return e;
    endfunction

    task automatic step();
        exp_t e;
        e = model_outputs();
        q.push_back(e);
        @(posedge clk);
        #1;
        cycle++;
        for (int i = 0; i < C; i++) begin
            if (!rst_n) begin
                m_run[i] = 1'b0; m_flag[i] = 1'b0; m_e[i] = 0;
            end else begin
                if (e.mat[i]) m_flag[i] = 1'b1;
                else if (match_clear[i]) m_flag[i] = 1'b0;
                if (!m_run[i]) begin
                    if (trigger[i] && !halt[i]) begin
                        m_run[i] = 1'b1; m_e[i] = 0;
                        m_cmp[i] = int'(compare_value[i*W +: W]);
                        m_psc[i] = int'(prescale[i*PW +: PW]);
                        m_ss[i]  = single_shot[i];
                    end
                end else if (halt[i]) begin
                    m_run[i] = 1'b0;
                end else if (e.mat[i] && m_ss[i]) begin
                    m_run[i] = 1'b0;
                end else begin
                    m_e[i]++;
                end
            end
        end
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic set_ch(input int i, input int cmp, input int psc, input bit ss);
        compare_value[i*W +: W] = W'(cmp);
        prescale[i*PW +: PW]    = PW'(psc);
        single_shot[i]          = ss;
    endtask

    task automatic pulse_trigger(input logic [C-1:0] m);
        trigger = m; step(); trigger = '0;
    endtask

    // Monitor: compares every channel against the expectation of the current cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                for (int i = 0; i < C; i++) begin
                    vectors++;
                    if (active[i] !== e.act[i] || match_occurred[i] !== e.mat[i] ||
                        match_flag[i] !== e.flg[i] || counter[i*W +: W] !== e.cnt[i*W +: W]) begin
                        miscompares++;
                        $display("FAIL ch%0d cyc%0d: act/match/flag/cnt got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                                 i, e.cyc, active[i], match_occurred[i], match_flag[i], counter[i*W +: W],
                                 e.act[i], e.mat[i], e.flg[i], e.cnt[i*W +: W]);
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < C; i++) begin
            m_run[i] = 0; m_flag[i] = 0; m_ss[i] = 1; m_e[i] = 0; m_cmp[i] = 0; m_psc[i] = 0;
        end
        rst_n = 1'b0; trigger = '0; halt = '0; single_shot = '0; match_clear = '0;
        compare_value = '0; prescale = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        steps(2);

        // Single-shot, no prescale, plus trigger+halt in IDLE on ch0 afterwards.
        set_ch(0, 5, 0, 1'b1);
        pulse_trigger(4'b0001);
        steps(9);
        halt = 4'b0001; pulse_trigger(4'b0001); halt = '0;
        steps(2);

        // Continuous with prescale on ch1; retrigger while counting; halt at counter=2.
        set_ch(1, 3, 2, 1'b0);
        pulse_trigger(4'b0010);
        steps(20);
        trigger = 4'b0010; steps(3); trigger = '0;
        steps(19);
        halt = 4'b0010; step(); halt = '0;
        steps(3);

        // Latching and independence: ch2 compare changed mid-count, ch3 matches every cycle.
        set_ch(2, 5, 1, 1'b0);
        set_ch(3, 0, 0, 1'b0);
        pulse_trigger(4'b1100);
        steps(4);
        set_ch(2, 1, 0, 1'b1);
        steps(25);

        // Flag priority: clear coincident with a match, then clear alone after halting.
        match_clear = 4'b1000; step(); match_clear = '0;
        steps(2);
        halt = 4'b1100; step(); halt = '0;
        steps(1);
        match_clear = 4'b1111; step(); match_clear = '0;
        steps(2);

        // Wrap: compare at the all-ones value.
        set_ch(0, 15, 0, 1'b1);
        pulse_trigger(4'b0001);
        steps(20);

        // Reset mid-count on all channels.
        for (int i = 0; i < C; i++) set_ch(i, 7, 1, 1'b0);
        pulse_trigger(4'b1111);
        steps(5);
        rst_n = 1'b0; steps(2); rst_n = 1'b1;
        steps(3);

        // Randomized phase.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < C; i++) begin
                trigger[i]     = ($urandom_range(0, 7) == 0);
                halt[i]        = ($urandom_range(0, 40) == 0);
                match_clear[i] = ($urandom_range(0, 7) == 0);
                set_ch(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            end
            rst_n = ($urandom_range(0, 600) != 0);
            step();
        end
        rst_n = 1'b1; trigger = '0; halt = '0; match_clear = '0;
        steps(2);

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
